dda_sample_streamer: RTL and testbench
======================================

# dda_sample_streamer

Output-side companion to the posit DDA core. It sequences the core's step enable and its initial-condition load, then snapshots the state variables v1/v2 once every decim+1 integration steps. Each snapshot is serialised as a byte-wide framed stream over a valid/ready handshake toward the chip's output pins. Stepping back-pressures, so no sample is ever lost: the core stalls while the previous frame is still in flight.

## Interface
- N, 16: posit width of v1/v2; multiple of 8.
- CW, 8: width of decimation counter and `decim`.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  1 = allow integration steps
- init  in  1  1-cycle pulse: reload initial conditions, restart sequence number
- decim  in  CW  sample every decim+1 steps
- v1  in  N  core state variable 1 (posit)
- v2  in  N  core state variable 2 (posit)
- dda_en  out  1  step/load enable to core
- dda_rst_n  out  1  core reset (0 with dda_en=1 loads ic1/ic2)
- data  out  8  stream byte
- valid  out  1  data valid
- ready  in  1  sink accepts byte

## Operation
- Control FSM, 2 states:
  - INIT: dda_rst_n=0, dda_en=1.
  - RUN: dda_rst_n=1, dda_en = run & !(due & tx_busy).
  - Outputs decode combinationally from the registered state.
- Transitions:
  - rst_n=0 → INIT.
  - INIT → RUN after one cycle.
  - RUN with init=1 → INIT; cnt←0, seq←0.
- Step counter cnt (CW bits): due = (cnt >= decim).
  - On each RUN cycle with dda_en=1: if due, cnt←0 and capture; else cnt←cnt+1.
  - The `>=` compare makes lowering decim mid-run take effect on the next step.
- Capture:
  - frame ← {0xA5, seq, v1 MSB-first, v2 MSB-first}; F = 2 + N/4 bytes (6 at N=16).
  - v1/v2 are the values present in the capture cycle, i.e. the state before that step's update.
  - seq←seq+1, mod 256; the first frame after init carries seq 0x00.
- TX FSM:
  - States: TX_IDLE (valid=0), TX_SEND (valid=1, data=frame[idx]).
  - Byte accepted when valid & ready; then idx←idx+1.
  - On the last byte accepted: → TX_IDLE, unless a capture occurs in the same cycle, in which case stay in TX_SEND with idx=0 and the new frame.
  - tx_busy = TX_SEND & !(ready & idx==F-1).
- run=0: dda_en=0, cnt held, an in-flight frame continues.
- init during a frame: the frame completes unmodified; no capture occurs in INIT.
- No captures occur while run=0 or in INIT.

## Timing
- Reset values (after the first edge with rst_n=0):
  - Outputs: dda_rst_n=0, dda_en=1, valid=0, data=0x00.
  - Internal: cnt=0, seq=0, frame=0, TX_IDLE, idx=0.
  - The core continuously loads ic while rst_n is held low.
- After rst_n rises: INIT for one more cycle, then RUN.
- Capture at edge t → valid=1 and data=0xA5 visible in cycle t+1.
- data/valid are registered and held stable while valid & !ready.
- ready=1 continuously: one byte per cycle, frame occupies F cycles.
- Minimum capture period is F cycles (decim=0, N=16: dda_en high 1 cycle in 6).
- decim+1 ≥ F with ready=1: dda_en never drops.
- A capture and the acceptance of the last byte may coincide; there is no bubble between frames.

## Test plan
- Reset/init: rst_n=0 for 3 cycles → dda_rst_n=0, dda_en=1, valid=0, data=0x00; release → exactly 1 further INIT cycle, then dda_rst_n=1, dda_en=run.
- Decimated stream: decim=7, run=1, ready=1, v1=0x4000, v2=0xC000 → frames A5 00 40 00 C0 00, then A5 01 40 00 C0 00, starting every 8 cycles; dda_en never low.
- Full rate: decim=0, ready=1 → back-to-back frames, seq increments per frame, dda_en pulses 1 cycle in 6, valid never drops after the first frame.
- Back-pressure: decim=7, ready=0 for 20 cycles while idx=2 → data/valid frozen at byte 2, dda_en low from the next due cycle until the last byte is accepted, then the next frame carries seq+1.
- Init mid-frame: pulse init at idx=3 → current frame finishes intact, one cycle dda_rst_n=0 & dda_en=1, next frame header A5 00.
- Sequence wrap: decim=7, 257 frames → seq bytes 0x00..0xFF, then 0x00; run=0 mid-test → dda_en=0, cnt held, resume counts from the held value.

Source files
------------

// File: rtl/dda_sample_streamer.sv
// dda_sample_streamer: sequences the DDA core's step enable and initial-condition
// load, snapshots v1/v2 every decim+1 steps and streams each snapshot as a
// byte-wide framed packet (A5, seq, v1, v2) over a valid/ready handshake.
module dda_sample_streamer #(
  parameter int N  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          init,
  input  logic [CW-1:0] decim,
  input  logic [N-1:0]  v1,
  input  logic [N-1:0]  v2,
  output logic          dda_en,
  output logic          dda_rst_n,
  output logic [7:0]    data,
  output logic          valid,
  input  logic          ready
);

  localparam int F  = 2 + N / 4;
  localparam int IW = $clog2(F);

  typedef enum logic {ST_INIT, ST_RUN} ctl_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_t;

  ctl_t            state, state_nx;
  tx_t             tx_state;
  logic [CW-1:0]   cnt;
  logic [7:0]      seq;
  logic [8*F-1:0]  frame;
  logic [IW-1:0]   idx;
  logic            due;
  logic            last_acc;
  logic            tx_busy;
  logic            capture;

  // Control decode, step gating and next control state.
  always_comb begin
    due       = (cnt >= decim);
    last_acc  = (tx_state == TX_SEND) && ready && (idx == IW'(F - 1));
    tx_busy   = (tx_state == TX_SEND) && !last_acc;
    dda_rst_n = (state == ST_RUN);
    dda_en    = (state == ST_INIT) ? 1'b1 : (run && !(due && tx_busy));
    capture   = (state == ST_RUN) && !init && dda_en && due;
    valid     = (tx_state == TX_SEND);
    data      = frame[8*F-1 -: 8];
    state_nx  = state;
    case (state)
      ST_INIT: state_nx = ST_RUN;
      ST_RUN:  if (init) state_nx = ST_INIT;
      default: state_nx = ST_INIT;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nx;
  end

  // Step counter and frame sequence number; init clears both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      seq <= '0;
    end else if (state == ST_RUN) begin
      if (init) begin
        cnt <= '0;
        seq <= '0;
      end else if (dda_en) begin
        if (due) begin
          cnt <= '0;
          seq <= seq + 8'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Frame register and transmit sequencer.
  // The frame is a shift register: the head byte is always the one on 'data',
  // so idx only tracks position for last-byte detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      idx      <= '0;
      frame    <= '0;
    end else if (capture) begin
      tx_state <= TX_SEND;
      idx      <= '0;
      frame    <= {8'hA5, seq, v1, v2};
    end else if (tx_state == TX_SEND && ready) begin
      frame <= {frame[8*F-9:0], 8'h00};
      if (last_acc) begin
        tx_state <= TX_IDLE;
        idx      <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dda_sample_streamer.sv
// Bench for dda_sample_streamer: queue-based stream model checked every cycle,
// plus directed scenarios with hand-computed byte and enable expectations.
module tb_dda_sample_streamer;
  localparam int N  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          init = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] decim = 8'd7;
  logic [N-1:0]  v1 = '0;
  logic [N-1:0]  v2 = '0;
  logic          dda_en, dda_rst_n, valid;
  logic [7:0]    data;

  dda_sample_streamer #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .init(init), .decim(decim),
    .v1(v1), .v2(v2), .dda_en(dda_en), .dda_rst_n(dda_rst_n),
    .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_on = 0;
  bit              m_init = 1;
  int              m_cnt = 0;
  int              m_seq = 0;
  byte unsigned    q[$];

  function automatic bit model_en();
    bit due, busy;
    due  = (m_cnt >= int'(decim));
    busy = (q.size() > 0) && !(ready && q.size() == 1);
    return m_init ? 1'b1 : (run && !(due && busy));
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_on = 1; m_init = 1; m_cnt = 0; m_seq = 0; q.delete();
    end else if (m_on) begin
      bit en;
      en = model_en();
      if (q.size() > 0 && ready) void'(q.pop_front());
      if (m_init) m_init = 0;
      else if (init) begin
        m_init = 1; m_cnt = 0; m_seq = 0;
      end else if (en) begin
        if (m_cnt >= int'(decim)) begin
          m_cnt = 0;
          q.push_back(8'hA5);
          q.push_back(8'(m_seq));
          q.push_back(v1[15:8]); q.push_back(v1[7:0]);
          q.push_back(v2[15:8]); q.push_back(v2[7:0]);
          m_seq = (m_seq + 1) % 256;
        end else m_cnt++;
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("dda_rst_n", dda_rst_n, int'(!m_init));
      chk("dda_en", dda_en, int'(model_en()));
      chk("valid", valid, int'(q.size() > 0));
      if (q.size() > 0) chk("data", data, q[0]);
    end
  end

  // Accepted-byte log.
  byte unsigned got[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && valid && ready) got.push_back(data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_bytes(input int n, input int limit);
    int k = 0;
    while (got.size() < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("byte_wait_timeout", int'(got.size() >= n), 1);
  endtask

  task automatic restart(input logic [CW-1:0] d);
    int k = 0;
    run = 1'b0;
    while (valid && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_timeout", int'(valid), 0);
    got.delete();
    decim = d;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    byte unsigned exp2[12];
    int lows, highs, vals;

    // Reset / init sequence
    run = 1'b1; ready = 1'b1; decim = 8'd7; v1 = 16'h4000; v2 = 16'hC000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dda_rst_n", dda_rst_n, 0);
    chk("rst_dda_en", dda_en, 1);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_hold_rst_n", dda_rst_n, 0);
    chk("init_hold_en", dda_en, 1);
    @(negedge clk);
    chk("run_rst_n", dda_rst_n, 1);
    chk("run_en", dda_en, 1);

    // Decimated stream, decim=7
    lows = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (!dda_en) lows++;
    end
    @(posedge clk); #1;
    exp2 = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'hC0, 8'h00,
             8'hA5, 8'h01, 8'h40, 8'h00, 8'hC0, 8'h00};
    chk("dec_count", int'(got.size() >= 12), 1);
    for (int i = 0; i < 12; i++) chk("dec_byte", got[i], exp2[i]);
    chk("dec_en_low", lows, 0);

    // Full rate, decim=0
    restart(8'd0);
    wait_bytes(24, 80);
    for (int k = 0; k < 4; k++) begin
      chk("full_hdr", got[6*k], 8'hA5);
      chk("full_seq", got[6*k+1], k);
    end
    highs = 0; vals = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dda_en) highs++;
      if (valid) vals++;
    end
    @(posedge clk); #1;
    chk("full_en_pulses", highs, 2);
    chk("full_valid_cycles", vals, 12);

    // Back-pressure at byte 2
    restart(8'd7);
    v1 = 16'h1234; v2 = 16'hABCD;
    wait_bytes(2, 40);
    ready = 1'b0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!dda_en) lows++;
      if (i == 19) begin
        chk("bp_data_frozen", data, 8'h12);
        chk("bp_valid_held", valid, 1);
      end
      @(posedge clk); #1;
      if (i == 19) ready = 1'b1;
    end
    chk("bp_en_low_cycles", lows, 18);
    chk("bp_count", int'(got.size() >= 12), 1);
    chk("bp_b2", got[2], 8'h12);
    chk("bp_b5", got[5], 8'hCD);
    chk("bp_hdr2", got[6], 8'hA5);
    chk("bp_seq2", got[7], 8'h01);

    // Init mid-frame at byte 3
    restart(8'd7);
    v1 = 16'h4000; v2 = 16'hC000;
    wait_bytes(3, 40);
    v1 = 16'h5555;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    @(negedge clk);
    chk("mid_init_rst_n", dda_rst_n, 0);
    chk("mid_init_en", dda_en, 1);
    chk("mid_init_valid", valid, 1);
    chk("mid_init_data", data, 8'hC0);
    wait_bytes(12, 40);
    for (int i = 0; i < 6; i++) chk("mid_frame", got[i], exp2[i]);
    chk("mid_next_hdr", got[6], 8'hA5);
    chk("mid_next_seq", got[7], 8'h00);
    chk("mid_next_v1", got[8], 8'h55);

    // Sequence wrap with a run=0 pause
    restart(8'd7);
    wait_bytes(600, 1300);
    run = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!dda_en) lows++;
      @(posedge clk); #1;
    end
    chk("pause_en_low", lows, 10);
    run = 1'b1;
    wait_bytes(6*257, 2500);
    for (int k = 0; k < 257; k++) chk("wrap_seq", got[6*k+1], k % 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
